// File: rtl/alu_cmd_ctrl.sv
// Command front end for the combinational alu. It registers one operation,
// captures the result one cycle later, and holds it until the consumer takes it.
module alu_cmd_ctrl #(
   parameter int BW    = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_opcode,
   input  logic [BW-1:0]    cmd_a,
   input  logic [BW-1:0]    cmd_b,
   input  logic             cmd_use_acc,
   output logic [BW-1:0]    alu_a,
   output logic [BW-1:0]    alu_b,
   output logic [3:0]       alu_opcode,
   input  logic [BW-1:0]    alu_out,
   input  logic [2:0]       alu_flags,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [BW-1:0]    rsp_data,
   output logic [2:0]       rsp_flags,
   output logic             rsp_err,
   output logic [BW-1:0]    acc,
   output logic             sticky_ovf,
   input  logic             sticky_clr,
   output logic [CNT_W-1:0] op_count
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       cmd_fire;
   logic       rsp_fire;
   logic       exec_ok;
   logic       exec_err;
   logic       ovf_set;

   // Both channels transfer on a rising edge where valid && ready are high;
   // the source holds its payload stable until that edge.
   assign cmd_ready = rst_n && (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign rsp_fire  = rsp_valid && rsp_ready;
   assign exec_ok   = (state == EXEC) && !alu_opcode[3];
   assign exec_err  = (state == EXEC) && alu_opcode[3];
   assign ovf_set   = exec_ok && alu_flags[2];

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_fire) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_fire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Operand registers keep their last value outside EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
      end else if (cmd_fire) begin
         alu_a      <= cmd_use_acc ? acc : cmd_a;
         alu_b      <= cmd_b;
         alu_opcode <= cmd_opcode;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_data  <= '0;
         rsp_flags <= '0;
         rsp_err   <= 1'b0;
      end else if (exec_ok) begin
         rsp_data  <= alu_out;
         rsp_flags <= alu_flags;
         rsp_err   <= 1'b0;
      end else if (exec_err) begin
         rsp_data  <= '0;
         rsp_flags <= '0;
         rsp_err   <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         op_count <= '0;
      end else if (exec_ok) begin
         acc      <= alu_out;
         op_count <= op_count + CNT_W'(1);
      end
   end

   // A new overflow capture takes priority over a clear in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sticky_ovf <= 1'b0;
      else        sticky_ovf <= (sticky_ovf && !sticky_clr) || ovf_set;
   end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed and random bench for alu_cmd_ctrl with a behavioural alu stand-in
// and an expected-response queue.
module tb_alu_cmd_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        cmd_use_acc;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_out;
  logic [2:0]  alu_flags;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_flags;
  logic        rsp_err;
  logic [15:0] acc;
  logic        sticky_ovf;
  logic        sticky_clr;
  logic [7:0]  op_count;

  int checks;
  int failures;

  logic [19:0] exp_q[$];
  logic [15:0] exp_acc;
  logic [7:0]  exp_cnt;
  logic        exp_sticky;

  alu_cmd_ctrl #(.BW(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .acc(acc), .sticky_ovf(sticky_ovf), .sticky_clr(sticky_clr),
    .op_count(op_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // alu stand-in; returns {ovf, neg, zero, result}
  function automatic logic [18:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [15:0] r;
    logic        v;
    v = 1'b0;
    case (op)
      4'd0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      4'd1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5, 4'd6, 4'd7: r = a;
      default: begin r = a ^ b; v = 1'b1; end
    endcase
    return {v, r[15], (r == 16'h0000), r};
  endfunction

  always_comb {alu_flags, alu_out} = alu_fn(alu_opcode, alu_a, alu_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // driver: one full command/response transaction, optionally with backpressure
  task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic use_acc, input logic clr_in_exec, input int hold);
    logic [15:0] ea;
    logic [18:0] r;
    logic [19:0] expv;
    ea = use_acc ? exp_acc : a;
    r  = alu_fn(op, ea, b);
    if (op[3]) begin
      exp_q.push_back({1'b1, 3'b000, 16'h0000});
    end else begin
      exp_q.push_back({1'b0, r});
      exp_acc = r[15:0];
      exp_cnt = exp_cnt + 8'd1;
    end
    exp_sticky = (exp_sticky && !clr_in_exec) || (!op[3] && r[18]);

    rsp_ready   = (hold == 0);
    cmd_valid   = 1'b1;
    cmd_opcode  = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_use_acc = use_acc;
    tick();
    cmd_valid   = 1'b0;
    cmd_a       = 16'($urandom_range(0, 65535));
    cmd_use_acc = 1'b0;
    check("alu_a", alu_a, ea);
    check("alu_b", alu_b, b);
    check("alu_opcode", alu_opcode, op);
    check("exec_cmd_ready", cmd_ready, 0);
    check("exec_rsp_valid", rsp_valid, 0);
    sticky_clr = clr_in_exec;
    tick();
    sticky_clr = 1'b0;
    check("rsp_latency", rsp_valid, 1);

    for (int i = 0; i < hold; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_rsp_data", rsp_data, r[15:0] & {16{!op[3]}});
      cmd_valid  = (i == 2);
      cmd_opcode = 4'h3;
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;

    if (exp_q.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      expv = exp_q.pop_front();
      check("rsp", {rsp_err, rsp_flags, rsp_data}, expv);
    end
    check("acc", acc, exp_acc);
    check("op_count", op_count, exp_cnt);
    check("sticky_ovf", sticky_ovf, exp_sticky);
    tick();
    check("post_rsp_valid", rsp_valid, 0);
    check("post_cmd_ready", cmd_ready, 1);
    check("held_opcode", alu_opcode, op);
  endtask

  initial begin
    logic [15:0] s_acc;
    logic [7:0]  s_cnt;
    logic        s_sticky;
    checks      = 0;
    failures    = 0;
    exp_acc     = 16'h0000;
    exp_cnt     = 8'h00;
    exp_sticky  = 1'b0;
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_opcode  = 4'h0;
    cmd_a       = 16'h0000;
    cmd_b       = 16'h0000;
    cmd_use_acc = 1'b0;
    rsp_ready   = 1'b1;
    sticky_clr  = 1'b0;

    // reset state
    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_outputs", {alu_a, alu_b, alu_opcode, rsp_valid, rsp_data, rsp_flags, rsp_err}, 0);
    check("rst_state", {acc, sticky_ovf, op_count}, 0);
    rst_n = 1'b1;
    tick();
    check("rel_cmd_ready", cmd_ready, 1);

    // ADD overflow
    do_op(4'd0, 16'd32767, 16'd1, 1'b0, 1'b0, 0);
    check("add_data", rsp_data, 16'h8000);
    check("add_flags", rsp_flags, 3'b110);
    check("add_err", rsp_err, 0);
    check("add_acc", acc, 16'h8000);
    check("add_sticky", sticky_ovf, 1);
    check("add_count", op_count, 1);

    // chaining through the accumulator
    do_op(4'd1, 16'h0000, 16'h0001, 1'b0, 1'b0, 0);
    check("sub_data", rsp_data, 16'hFFFF);
    check("sub_flags", rsp_flags, 3'b010);
    do_op(4'd4, 16'h1234, 16'hFFFF, 1'b1, 1'b0, 0);
    check("xor_alu_a", alu_a, 16'hFFFF);
    check("xor_data", rsp_data, 16'h0000);
    check("xor_flags", rsp_flags, 3'b001);

    // backpressure with a stray command pulse
    do_op(4'd2, 16'hF0F0, 16'h3C3C, 1'b0, 1'b0, 5);
    check("bp_data", rsp_data, 16'h3030);

    // reserved opcode
    s_acc    = acc;
    s_cnt    = op_count;
    s_sticky = sticky_ovf;
    do_op(4'b1010, 16'h1234, 16'h00FF, 1'b0, 1'b0, 0);
    check("rsv_err", rsp_err, 1);
    check("rsv_data", rsp_data, 0);
    check("rsv_flags", rsp_flags, 0);
    check("rsv_acc", acc, s_acc);
    check("rsv_count", op_count, s_cnt);
    check("rsv_sticky", sticky_ovf, s_sticky);

    // sticky clear alone, then clear colliding with a new overflow
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    exp_sticky = 1'b0;
    check("sticky_cleared", sticky_ovf, 0);
    do_op(4'd0, 16'h7000, 16'h7000, 1'b0, 1'b1, 0);
    check("sticky_set_wins", sticky_ovf, 1);

    // random mix
    for (int i = 0; i < 12; i++) begin
      do_op(4'($urandom_range(0, 15)), 16'($urandom_range(0, 65535)),
            16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), (i % 4 == 0) ? 2 : 0);
    end

    // reset during EXEC discards the operation
    do_op(4'd0, 16'd5, 16'd7, 1'b0, 1'b0, 0);
    cmd_valid  = 1'b1;
    cmd_opcode = 4'd0;
    cmd_a      = 16'd100;
    cmd_b      = 16'd200;
    tick();
    cmd_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("mid_rst_cmd_ready", cmd_ready, 0);
    check("mid_rst_acc", acc, 0);
    check("mid_rst_alu_a", alu_a, 0);
    tick();
    rst_n = 1'b1;
    exp_acc    = 16'h0000;
    exp_cnt    = 8'h00;
    exp_sticky = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_no_rsp", rsp_valid, 0);
      check("mid_rst_acc_hold", acc, 0);
    end
    check("mid_rst_count", op_count, 0);

    // counter wrap after 256 completed ops
    for (int i = 0; i < 256; i++) begin
      do_op(4'd0, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
            1'b0, 1'b0, 0);
    end
    check("count_wrap", op_count, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
